// File: rtl/aes_iterative_encrypt.sv
// Purpose : iterative AES encryptor; one shared round evaluated per clock, round keys supplied pre-expanded.
// Latency : NR+1 clocks from the accept edge to the emit edge; one block every NR+1 clocks at best.
// Backpr. : out_valid/ciphertext hold until out_ready; in_ready is low while running or while output is stalled.
// Ports   : clk, rst_n (async, active-low), sys_en (freezes all state when 0),
//           in_valid/in_ready/plaintext (upstream), round_keys_flat (rk[k] = [k*128 +: 128]),
//           out_valid/out_ready/ciphertext (downstream), busy (high while rounds are in progress).
module aes_iterative_encrypt #(
  parameter int NR = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sys_en,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [127:0]          plaintext,
  input  logic [(NR+1)*128-1:0] round_keys_flat,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [127:0]          ciphertext,
  output logic                  busy
);

  localparam int            CW       = $clog2(NR + 1);
  localparam logic [CW-1:0] RND_ONE  = CW'(1);
  localparam logic [CW-1:0] RND_LAST = CW'(NR);

  // S-box table, entry 0 in the top byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} fsm_e;

  fsm_e          fsm_q;
  logic [127:0]  state_q;
  logic [CW-1:0] round_cnt_q;
  logic          out_valid_q;
  logic          busy_q;

  logic [127:0]  rk [NR+1];
  logic [127:0]  round_d;
  logic [127:0]  load_d;

  for (genvar k = 0; k <= NR; k++) begin : g_rk
    assign rk[k] = round_keys_flat[k*128 +: 128];
  end

  // Byte b sits at bit offset (255-b)*8, and 255-b is simply ~b.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
  // Byte i of the block is row i%4, column i/4.
  function automatic logic [127:0] aes_round(input logic [127:0] s,
                                             input logic [127:0] key,
                                             input logic         mix);
    logic [7:0]   sb [16];
    logic [7:0]   sr [16];
    logic [7:0]   mc [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] r;
    for (int i = 0; i < 16; i++) sb[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++) begin
      for (int rw = 0; rw < 4; rw++) sr[4*c+rw] = sb[4*((c+rw)%4)+rw];
    end
    for (int c = 0; c < 4; c++) begin
      a0 = sr[4*c];
      a1 = sr[4*c+1];
      a2 = sr[4*c+2];
      a3 = sr[4*c+3];
      mc[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      mc[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      mc[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      mc[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = (mix ? mc[i] : sr[i]) ^ key[127-8*i -: 8];
    return r;
  endfunction

  // The final round skips MixColumns.
  assign round_d = aes_round(state_q, rk[round_cnt_q], round_cnt_q != RND_LAST);
  assign load_d  = plaintext ^ rk[0];

  // Ready in DONE only when the current result leaves this cycle, giving back-to-back accept.
  assign in_ready   = (fsm_q == S_IDLE) | ((fsm_q == S_DONE) & out_ready);
  assign out_valid  = out_valid_q;
  assign busy       = busy_q;
  assign ciphertext = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= S_IDLE;
      state_q     <= '0;
      round_cnt_q <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else if (sys_en) begin
      case (fsm_q)
        S_IDLE: begin
          if (in_valid) begin
            state_q     <= load_d;
            round_cnt_q <= RND_ONE;
            busy_q      <= 1'b1;
            fsm_q       <= S_RUN;
          end
        end
        S_RUN: begin
          state_q     <= round_d;
          round_cnt_q <= round_cnt_q + RND_ONE;
          if (round_cnt_q == RND_LAST) begin
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
            fsm_q       <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (in_valid) begin
              state_q     <= load_d;
              round_cnt_q <= RND_ONE;
              busy_q      <= 1'b1;
              fsm_q       <= S_RUN;
            end else begin
              fsm_q <= S_IDLE;
            end
          end
        end
        default: begin
          fsm_q       <= S_IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_iterative_encrypt.sv
// Purpose : bench for aes_iterative_encrypt (NR=10 and NR=14 instances) against an AES reference model.
// Latency : handshakes are observed on the falling edge; latency is counted in clocks from accept to emit.
// Backpr. : out_ready is driven directly, both held low and randomly toggled.
module tb_aes_iterative_encrypt;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, sys_en;
  logic          in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0]  pt, ct;
  logic [1407:0] rkf;
  logic          in_valid14, in_ready14, out_valid14, out_ready14, busy14;
  logic [127:0]  pt14, ct14;
  logic [1919:0] rkf14;

  aes_iterative_encrypt #(.NR(10)) dut (
    .clk(clk), .rst_n(rst_n), .sys_en(sys_en), .in_valid(in_valid), .in_ready(in_ready),
    .plaintext(pt), .round_keys_flat(rkf), .out_valid(out_valid), .out_ready(out_ready),
    .ciphertext(ct), .busy(busy));

  aes_iterative_encrypt #(.NR(14)) dut14 (
    .clk(clk), .rst_n(rst_n), .sys_en(sys_en), .in_valid(in_valid14), .in_ready(in_ready14),
    .plaintext(pt14), .round_keys_flat(rkf14), .out_valid(out_valid14), .out_ready(out_ready14),
    .ciphertext(ct14), .busy(busy14));

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [255:0] C3_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] C_PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  int n_cmp = 0, n_bad = 0, cyc = 0;
  int acc_cnt = 0, emit_cnt = 0, last_acc = 0, last_emit = 0, last_lat = 0;
  int acc14 = 0, emit14 = 0, lat14 = 0;
  logic [127:0] last_ct, last_ct14;
  logic [255:0] cur_key, cur_key14;
  logic [127:0] exp_q[$], exp14_q[$];
  int           acc_q[$], acc14_q[$];
  logic [7:0]   sbox_tb [256];

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction

  // S-box derived from the field inverse followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int b = 0; b < 256; b++) begin
      inv = 8'h00;
      for (int x = 1; x < 256; x++) if (gmul(8'(b), 8'(x)) == 8'h01) inv = 8'(x);
      sbox_tb[b] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox_tb[w[31:24]], sbox_tb[w[23:16]], sbox_tb[w[15:8]], sbox_tb[w[7:0]]};
  endfunction

  // Key schedule; key is left-aligned in 256 bits, rk[k] lands at [k*128 +: 128].
  function automatic logic [1919:0] expand(input logic [255:0] key, input int nk);
    logic [31:0]   w [60];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1919:0] f;
    int            nr;
    nr = nk + 6;
    rc = 8'h01;
    f  = '0;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int k = 0; k <= nr; k++) f[k*128 +: 128] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
    return f;
  endfunction

  function automatic logic [127:0] aes_ref(input logic [255:0] key, input int nk, input logic [127:0] p);
    logic [1919:0] ks;
    logic [7:0]    s [16];
    logic [7:0]    t [16];
    logic [7:0]    coef [4];
    logic [7:0]    acc;
    logic [127:0]  r;
    int            nr;
    ks = expand(key, nk);
    nr = nk + 6;
    coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
    for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8] ^ ks[127-8*i -: 8];
    for (int rd = 1; rd <= nr; rd++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox_tb[s[i]];
      for (int c = 0; c < 4; c++)
        for (int rw = 0; rw < 4; rw++) s[4*c+rw] = t[4*((c+rw)%4)+rw];
      if (rd < nr) begin
        for (int c = 0; c < 4; c++)
          for (int rw = 0; rw < 4; rw++) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++) acc = acc ^ gmul(coef[(j-rw+4)%4], s[4*c+j]);
            t[4*c+rw] = acc;
          end
        for (int i = 0; i < 16; i++) s[i] = t[i];
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ ks[rd*128 + 127 - 8*i -: 8];
    end
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = s[i];
    return r;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: observe handshakes on the falling edge, return just after the rising edge.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (sys_en && out_valid && out_ready) begin
      emit_cnt++;
      last_emit = cyc;
      last_ct   = ct;
      chk("emit_pending", 128'(exp_q.size() > 0), 128'h1);
      if (exp_q.size() > 0) begin
        chk("sb_ct", ct, exp_q.pop_front());
        last_lat = cyc - acc_q.pop_front();
      end
    end
    if (sys_en && in_valid && in_ready) begin
      acc_cnt++;
      last_acc = cyc;
      exp_q.push_back(aes_ref(cur_key, 4, pt));
      acc_q.push_back(cyc);
    end
    if (sys_en && out_valid14 && out_ready14) begin
      emit14++;
      last_ct14 = ct14;
      chk("emit14_pending", 128'(exp14_q.size() > 0), 128'h1);
      if (exp14_q.size() > 0) begin
        chk("sb14_ct", ct14, exp14_q.pop_front());
        lat14 = cyc - acc14_q.pop_front();
      end
    end
    if (sys_en && in_valid14 && in_ready14) begin
      acc14++;
      exp14_q.push_back(aes_ref(cur_key14, 8, pt14));
      acc14_q.push_back(cyc);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_key(input logic [127:0] k);
    logic [1919:0] f;
    cur_key = {k, 128'h0};
    f       = expand(cur_key, 4);
    rkf     = f[1407:0];
  endtask

  task automatic set_key14(input logic [255:0] k);
    cur_key14 = k;
    rkf14     = expand(k, 8);
  endtask

  task automatic send(input logic [127:0] p);
    int n0 = acc_cnt;
    int g  = 0;
    pt       = p;
    in_valid = 1'b1;
    while (acc_cnt == n0 && g < 100) begin tick(); g++; end
    in_valid = 1'b0;
    chk("accept_seen", 128'(acc_cnt != n0), 128'h1);
  endtask

  task automatic wait_emit(input int target, input bit rand_rdy);
    int g = 0;
    while (emit_cnt < target && g < 300) begin
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
      tick();
      g++;
    end
    out_ready = 1'b1;
    chk("emit_seen", 128'(emit_cnt >= target), 128'h1);
  endtask

  task automatic wait_out_valid();
    int g = 0;
    while (!out_valid && g < 50) begin tick(); g++; end
    chk("out_valid_seen", 128'(out_valid), 128'h1);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    logic [127:0] hold;
    int           e0, a0, first_emit, g;

    rst_n = 1'b0; sys_en = 1'b1;
    in_valid = 1'b0; out_ready = 1'b1; pt = '0; rkf = '0;
    in_valid14 = 1'b0; out_ready14 = 1'b1; pt14 = '0; rkf14 = '0;
    cur_key = '0; cur_key14 = '0; last_ct = '0; last_ct14 = '0;
    build_sbox();
    #12;
    chk("rst_flags", 128'({out_valid, in_ready, busy}), 128'b010);
    chk("rst_ct", ct, 128'h0);
    chk("rst14_flags", 128'({out_valid14, in_ready14, busy14}), 128'b010);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // FIPS-197 C.1
    set_key(C1_KEY);
    send(C_PT);
    chk("run_flags", 128'({out_valid, in_ready, busy}), 128'b001);
    wait_emit(emit_cnt + 1, 1'b0);
    chk("c1_ct", last_ct, C1_CT);
    chk("c1_latency", 128'(last_lat), 128'd11);
    chk("c1_idle", 128'({out_valid, in_ready, busy}), 128'b010);

    // Backpressure: 20 cycles of out_ready=0
    set_key(rnd128());
    out_ready = 1'b0;
    send(rnd128());
    wait_out_valid();
    hold = ct;
    e0   = emit_cnt;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("bp_ct_hold", ct, hold);
      chk("bp_flags", 128'({out_valid, in_ready, busy}), 128'b100);
    end
    chk("bp_no_emit", 128'(emit_cnt), 128'(e0));
    out_ready = 1'b1;
    tick();
    chk("bp_one_emit", 128'(emit_cnt), 128'(e0 + 1));
    chk("bp_idle", 128'({out_valid, in_ready, busy}), 128'b010);

    // Back-to-back: C.1 block, then all-zero block under the zero key
    set_key(C1_KEY);
    a0 = acc_cnt;
    e0 = emit_cnt;
    pt = C_PT;
    in_valid = 1'b1;
    g = 0;
    while (acc_cnt == a0 && g < 20) begin tick(); g++; end
    pt = '0;
    wait_out_valid();
    set_key(128'h0);
    tick();
    first_emit = last_emit;
    in_valid = 1'b0;
    chk("b2b_ct1", last_ct, C1_CT);
    chk("b2b_accept_in_emit_cycle", 128'(last_acc), 128'(first_emit));
    wait_emit(e0 + 2, 1'b0);
    chk("b2b_ct2", last_ct, Z_CT);
    chk("b2b_spacing", 128'(last_emit - first_emit), 128'd11);
    chk("b2b_accepts", 128'(acc_cnt - a0), 128'd2);

    // sys_en low for 5 cycles at round 4
    set_key(rnd128());
    send(rnd128());
    repeat (3) tick();
    hold = ct;
    sys_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_state", ct, hold);
      chk("stall_flags", 128'({out_valid, busy}), 128'b01);
    end
    sys_en = 1'b1;
    wait_emit(emit_cnt + 1, 1'b0);
    chk("stall_latency", 128'(last_lat), 128'd16);

    // sys_en low while a result waits: no emit, no accept
    set_key(rnd128());
    out_ready = 1'b0;
    send(rnd128());
    wait_out_valid();
    e0 = emit_cnt;
    sys_en = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
    repeat (3) tick();
    chk("dstall_no_emit", 128'(emit_cnt), 128'(e0));
    chk("dstall_flags", 128'({out_valid, busy}), 128'b10);
    in_valid = 1'b0; sys_en = 1'b1;
    tick();
    chk("dstall_emit", 128'(emit_cnt), 128'(e0 + 1));
    chk("dstall_idle", 128'({out_valid, in_ready, busy}), 128'b010);

    // Reset at round 6 discards the block
    set_key(rnd128());
    send(rnd128());
    repeat (5) tick();
    rst_n = 1'b0;
    #2;
    chk("mid_rst_flags", 128'({out_valid, in_ready, busy}), 128'b010);
    chk("mid_rst_ct", ct, 128'h0);
    exp_q.delete();
    acc_q.delete();
    tick();
    rst_n = 1'b1;
    set_key(rnd128());
    send(rnd128());
    wait_emit(emit_cnt + 1, 1'b0);
    chk("post_rst_latency", 128'(last_lat), 128'd11);

    // Random keys/blocks with random downstream stalls
    for (int n = 0; n < 6; n++) begin
      set_key(rnd128());
      send(rnd128());
      wait_emit(emit_cnt + 1, 1'b1);
    end

    // NR=14: FIPS-197 C.3, then a random AES-256 block
    for (int n = 0; n < 2; n++) begin
      set_key14(n == 0 ? C3_KEY : {rnd128(), rnd128()});
      pt14 = (n == 0) ? C_PT : rnd128();
      a0 = acc14;
      e0 = emit14;
      in_valid14 = 1'b1;
      g = 0;
      while (acc14 == a0 && g < 20) begin tick(); g++; end
      in_valid14 = 1'b0;
      g = 0;
      while (emit14 == e0 && g < 60) begin tick(); g++; end
      chk("c3_emit_seen", 128'(emit14 - e0), 128'd1);
      chk("c3_latency", 128'(lat14), 128'd15);
      if (n == 0) chk("c3_ct", last_ct14, C3_CT);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
